// File: rtl/dff_resp_checker.sv
// Response checker for a D flip-flop with preset/clear: compares (q,qb) against a predicted pair.
// Build option DFF_CHK_BOTH_ASSERT_ERR_EN: pre=clr=1 expects (1,1) instead of skipping to SYNC.
module dff_resp_checker (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       d,
   input  logic       pre,
   input  logic       clr,
   input  logic       q,
   input  logic       qb,
   output logic       err,
   output logic       err_sticky,
   output logic [7:0] err_count,
   output logic [7:0] chk_count,
   output logic [1:0] state
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SYNC  = 2'd1,
      CHECK = 2'd2,
      FAIL  = 2'd3
   } state_t;

   state_t st;
   logic   exp_q;
   logic   both;
   logic   skip;
   logic   eq, eqb;
   logic   mismatch;
   logic   nxt_exp_q;

   assign state = st;
   assign both  = pre & clr;

`ifdef DFF_CHK_BOTH_ASSERT_ERR_EN
   assign skip = 1'b0;
`else
   assign skip = both;
`endif

   always_comb begin
      eq  = exp_q;
      eqb = ~exp_q;
      if (pre && !clr) begin
         eq  = 1'b1;
         eqb = 1'b0;
      end else if (clr && !pre) begin
         eq  = 1'b0;
         eqb = 1'b1;
      end else if (both) begin
         eq  = 1'b1;
         eqb = 1'b1;
      end
   end

   // q==qb is illegal unless both asynchronous controls are asserted
   assign mismatch  = (q != eq) || (qb != eqb) || ((q == qb) && !both);
   assign nxt_exp_q = (pre && !clr) ? 1'b1 : ((clr && !pre) ? 1'b0 : d);

   always_ff @(posedge clk) begin
      if (rst) begin
         st         <= IDLE;
         err        <= 1'b0;
         err_sticky <= 1'b0;
         err_count  <= '0;
         chk_count  <= '0;
         exp_q      <= 1'b0;
      end else begin
         err <= 1'b0;
         case (st)
            IDLE: begin
               if (en) st <= SYNC;
            end
            SYNC: begin
               if (!en) begin
                  st <= IDLE;
               end else begin
                  exp_q <= d;
                  st    <= CHECK;
               end
            end
            CHECK, FAIL: begin
               if (!en) begin
                  st <= IDLE;
               end else if (skip) begin
                  exp_q <= d;
                  if (st == CHECK) st <= SYNC;
               end else begin
                  exp_q <= nxt_exp_q;
                  if (chk_count != 8'hFF) chk_count <= chk_count + 8'd1;
                  if (mismatch) begin
                     err        <= 1'b1;
                     err_sticky <= 1'b1;
                     st         <= FAIL;
                     if (err_count != 8'hFF) err_count <= err_count + 8'd1;
                  end
               end
            end
            default: st <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dff_resp_checker.sv
// Scoreboard bench for dff_resp_checker: stimulus queues hand-computed expectations, a monitor checks them.
module tb_dff_resp_checker;

`ifdef DFF_CHK_BOTH_ASSERT_ERR_EN
   localparam int BOTH = 1;
`else
   localparam int BOTH = 0;
`endif
   localparam int C = 7 + 2 * BOTH;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0, d = 1'b0, pre = 1'b0, clr = 1'b0, tq = 1'b0, tqb = 1'b1;
   logic       err, err_sticky;
   logic [7:0] err_count, chk_count;
   logic [1:0] state;

   typedef struct {
      string nm;
      int    st, e, s, ec, cc;
   } exp_t;

   exp_t sb[$];
   int   n_pass = 0;
   int   n_total = 0;

   dff_resp_checker dut (
      .clk(clk), .rst(rst), .en(en), .d(d), .pre(pre), .clr(clr), .q(tq), .qb(tqb),
      .err(err), .err_sticky(err_sticky), .err_count(err_count),
      .chk_count(chk_count), .state(state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
   endtask

   // Monitor: outputs are registered, so one expectation per edge, checked 1ns after it
   always @(posedge clk) begin
      #1;
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         chk({e.nm, ".state"}, int'(state), e.st);
         chk({e.nm, ".err"}, int'(err), e.e);
         chk({e.nm, ".sticky"}, int'(err_sticky), e.s);
         chk({e.nm, ".err_count"}, int'(err_count), e.ec);
         chk({e.nm, ".chk_count"}, int'(chk_count), e.cc);
      end
   end

   task automatic step(input logic r, input logic ie, input logic id, input logic ip,
                       input logic ic, input logic iq, input logic iqb,
                       input int st, input int e, input int s, input int ec, input int cc,
                       input string nm);
      exp_t x;
      @(negedge clk);
      rst = r; en = ie; d = id; pre = ip; clr = ic; tq = iq; tqb = iqb;
      x.nm = nm; x.st = st; x.e = e; x.s = s; x.ec = ec; x.cc = cc;
      sb.push_back(x);
   endtask

   initial begin
      int ec, cc, budget;
      //    rst en d pre clr q qb   st e s ec cc
      step(1, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, "reset");
      step(0, 1, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0, "en_sync");
      step(0, 1, 1, 0, 0, 0, 1,  2, 0, 0, 0, 0, "sync_cap");
      step(0, 1, 0, 0, 0, 1, 0,  2, 0, 0, 0, 1, "chk1");
      step(0, 1, 1, 0, 0, 0, 1,  2, 0, 0, 0, 2, "chk2");
      step(0, 1, 0, 0, 0, 1, 0,  2, 0, 0, 0, 3, "chk3");
      // exp_q must take the forced value, not d
      step(0, 1, 0, 1, 0, 1, 0,  2, 0, 0, 0, 4, "pre");
      step(0, 1, 1, 0, 0, 1, 0,  2, 0, 0, 0, 5, "pre_follow");
      step(0, 1, 1, 0, 1, 0, 1,  2, 0, 0, 0, 6, "clr");
      step(0, 1, 0, 0, 0, 0, 1,  2, 0, 0, 0, 7, "clr_follow");
      step(0, 1, 0, 1, 1, 1, 1,  (BOTH != 0) ? 2 : 1, 0, 0, 0, 7 + BOTH, "both");
      step(0, 1, 1, 1, 0, 1, 0,  2, 0, 0, 0, C, "after_both");
      step(0, 1, 1, 0, 0, 1, 0,  2, 0, 0, 0, C + 1, "match");
      // en=0 from CHECK, then resync with garbage q/qb that must not be compared
      step(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, C + 1, "en_off");
      step(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, C + 1, "idle_hold");
      step(0, 1, 0, 0, 0, 0, 0,  1, 0, 0, 0, C + 1, "resync");
      step(0, 1, 1, 0, 0, 0, 0,  2, 0, 0, 0, C + 1, "resync_cap");
      step(0, 1, 0, 0, 0, 0, 1,  3, 1, 1, 1, C + 2, "mismatch");
      step(0, 1, 0, 0, 0, 0, 1,  3, 0, 1, 1, C + 3, "fail_match");
      step(0, 1, 0, 0, 0, 0, 0,  3, 1, 1, 2, C + 4, "q_eq_qb");
      step(0, 1, 0, 1, 1, 1, 0,  3, BOTH, 1, 2 + BOTH, C + 4 + BOTH, "fail_both");
      ec = 2 + BOTH;
      cc = C + 4 + BOTH;
      for (int i = 0; i < 300; i++) begin
         ec = (ec < 255) ? ec + 1 : 255;
         cc = (cc < 255) ? cc + 1 : 255;
         step(0, 1, 0, 0, 0, 0, 0,  3, 1, 1, ec, cc, "sat");
      end
      step(1, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, "rst_fail");
      step(0, 1, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, "post_rst_sync");
      step(0, 1, 1, 0, 0, 0, 0,  2, 0, 0, 0, 0, "post_rst_cap");
      step(0, 1, 0, 0, 0, 1, 0,  2, 0, 0, 0, 1, "post_rst_chk");
      budget = 0;
      while (sb.size() > 0 && budget < 20) begin
         @(posedge clk);
         budget++;
      end
      #2;
      if (sb.size() > 0) chk("drain", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
